pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 23 ++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/stall control bundle between pipeline and pipe_ctrl.
// master = pipeline side (drives requests), slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        ex_start;
  logic [5:0]  ex_cycles;
  logic        flush_req;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_busy;
  logic        ex_done;
  logic [31:0] perf_stall_cnt;

  modport master (
    output stallreq_id, ex_start, ex_cycles, flush_req,
    input  stall, flush, ex_busy, ex_done, perf_stall_cnt
  );

  modport slave (
    input  stallreq_id, ex_start, ex_cycles, flush_req,
    output stall, flush, ex_busy, ex_done, perf_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush FSM (IDLE/EXEC/DONE/FLUSH); ports clk, rst (async low),
// bus (slave: requests in; stall/flush/ex_busy/ex_done/perf out). PIPE_CTRL_PERF_EN adds stall counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE,
    FLUSH
  } state_t;

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic [5:0] n_eff;
  logic       hold_ex;
  logic       hold_id;
  logic [5:0] stall_w;

  // A zero-length op still occupies EX for one cycle.
  assign n_eff = (bus.ex_cycles == 6'd0) ? 6'd1 : bus.ex_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold_ex  = 1'b0;
    hold_id  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.flush_req) begin
          state_nx = FLUSH;
          cnt_nx   = 6'd0;
        end else if (bus.ex_start) begin
          hold_ex = 1'b1;
          if (n_eff == 6'd1) begin
            state_nx = DONE;
            cnt_nx   = 6'd0;
          end else begin
            state_nx = EXEC;
            cnt_nx   = n_eff - 6'd1;
          end
        end else begin
          hold_id  = bus.stallreq_id;
          state_nx = IDLE;
        end
      end
      EXEC: begin
        if (bus.flush_req) begin
          state_nx = FLUSH;
          cnt_nx   = 6'd0;
        end else begin
          hold_ex = 1'b1;
          cnt_nx  = cnt - 6'd1;
          if (cnt == 6'd1) begin
            state_nx = DONE;
          end
        end
      end
      FLUSH: begin
        cnt_nx   = 6'd0;
        state_nx = bus.flush_req ? FLUSH : IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 6'd0;
      end
    endcase
  end

  // Outputs are gated by rst so they read zero the moment reset asserts.
  always_comb begin
    stall_w = 6'b000000;
    if (rst) begin
      if (hold_ex) begin
        stall_w = 6'b001111;
      end else if (hold_id) begin
        stall_w = 6'b000111;
      end
    end
  end

  assign bus.stall   = stall_w;
  assign bus.flush   = (state == FLUSH);
  assign bus.ex_done = (state == DONE);
  assign bus.ex_busy = rst & ((state == EXEC) |
                       (((state == IDLE) | (state == DONE)) &
                        bus.ex_start & ~bus.flush_req));

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= 32'h0000_0000;
    end else if ((|stall_w) && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_cnt;
`else
  assign bus.perf_stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; directed scenarios then random traffic.
// Expected outputs come from a cycle-count reference model, checked by a negedge monitor.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] perf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: remaining hold cycles, pending done/flush, stall count.
  int     m_left = 0;
  bit     m_done = 1'b0;
  bit     m_flush = 1'b0;
  longint m_perf = 0;

  function automatic exp_t dut_out();
    exp_t g;
    g.stall = bus.stall;
    g.flush = bus.flush;
    g.busy  = bus.ex_busy;
    g.done  = bus.ex_done;
    g.perf  = bus.perf_stall_cnt;
    return g;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s t=%0t got stall=%b flush=%b busy=%b done=%b perf=%h exp stall=%b flush=%b busy=%b done=%b perf=%h",
               name, $time, got.stall, got.flush, got.busy, got.done, got.perf,
               exp.stall, exp.flush, exp.busy, exp.done, exp.perf);
    end
  endtask

  always @(negedge clk) begin
    if (rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("cycle", dut_out(), e);
    end
  end

  task automatic step(input bit sid, input bit es,
                      input logic [5:0] cyc, input bit fr);
    exp_t e;
    int   n;
    bus.stallreq_id = sid;
    bus.ex_start    = es;
    bus.ex_cycles   = cyc;
    bus.flush_req   = fr;
    e       = '0;
    e.flush = m_flush;
    e.done  = m_done;
    e.perf  = PERF ? m_perf[31:0] : 32'h0;
    if (fr) begin
      e.busy  = (m_left > 0);
      m_flush = 1'b1;
      m_left  = 0;
      m_done  = 1'b0;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (m_left > 0) begin
      e.stall = 6'b001111;
      e.busy  = 1'b1;
      m_left--;
      m_done  = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (es) begin
        n       = (cyc == 6'd0) ? 1 : int'(cyc);
        e.stall = 6'b001111;
        e.busy  = 1'b1;
        m_left  = n - 1;
        m_done  = (n == 1);
      end else if (sid) begin
        e.stall = 6'b000111;
      end
    end
    if (e.stall != 6'b0 && m_perf < 64'hFFFF_FFFF) m_perf++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle with active requests on the inputs.
  task automatic do_reset();
    bus.stallreq_id = 1'b1;
    bus.ex_start    = 1'b1;
    bus.ex_cycles   = 6'd7;
    bus.flush_req   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", dut_out(), exp_t'('0));
    @(posedge clk);
    #1;
    check("reset_hold", dut_out(), exp_t'('0));
    bus.stallreq_id = 1'b0;
    bus.ex_start    = 1'b0;
    rst     = 1'b1;
    m_left  = 0;
    m_done  = 1'b0;
    m_flush = 1'b0;
    m_perf  = 0;
  endtask

  initial begin
    rst             = 1'b0;
    bus.stallreq_id = 1'b1;
    bus.ex_start    = 1'b1;
    bus.ex_cycles   = 6'd3;
    bus.flush_req   = 1'b0;
    #1;
    check("reset_state", dut_out(), exp_t'('0));
    repeat (2) @(posedge clk);
    #1;
    bus.stallreq_id = 1'b0;
    bus.ex_start    = 1'b0;
    rst = 1'b1;

    step(1'b0, 1'b1, 6'd5, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 6'd0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 6'd1, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 6'd4, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 6'd6, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 6'd0, 1'b1);
    idle(3);
    step(1'b0, 1'b1, 6'd5, 1'b1);
    idle(3);
    step(1'b0, 1'b1, 6'd2, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b1);
    step(1'b0, 1'b0, 6'd0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 6'd8, 1'b0);
    idle(2);
    do_reset();
    idle(2);
    step(1'b0, 1'b1, 6'd10, 1'b0);
    idle(9);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] cyc;
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        cyc = ($urandom_range(9) == 0) ? 6'($urandom_range(63))
                                       : 6'($urandom_range(12));
        step($urandom_range(99) < 30, $urandom_range(99) < 20,
             cyc, $urandom_range(99) < 5);
      end
    end
    idle(1);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
